aes_round_controller: RTL and testbench

//  Sequences one AES-128 encryption through the shared iterative round datapath
//  (sub_bytes -> shift_rows -> mix_columns -> add_round_key, combinational, external).

---
 rtl/aes_round_controller.sv | 107 ++++++++++
 tb/tb_aes_round_controller.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_controller.sv
// Sequences one AES-128 block through an external combinational round datapath.
// Latency: 12 cycles from accept to out_valid with no key stalls; each key_ack-low cycle adds one.
// Backpressure: in_ready only in IDLE; key_ack low stalls a round; out_valid/out_block hold until out_ready.
module aes_round_controller #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic         key_req,
    output logic [3:0]   key_round,
    input  logic         key_ack,
    input  logic [127:0] key_in,
    output logic [127:0] dp_state,
    output logic [127:0] dp_key,
    output logic         dp_last,
    input  logic [127:0] dp_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         busy
);

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } ctrl_state_t;

    ctrl_state_t  st_q, st_nxt;
    logic [3:0]   rnd_q, rnd_nxt;
    logic [127:0] state_q, state_nxt;
    logic [127:0] hold_q, hold_nxt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            st_q    <= IDLE;
            rnd_q   <= 4'd0;
            state_q <= 128'd0;
            hold_q  <= 128'd0;
        end else begin
            st_q    <= st_nxt;
            rnd_q   <= rnd_nxt;
            state_q <= state_nxt;
            hold_q  <= hold_nxt;
        end
    end

    always_comb begin
        st_nxt    = st_q;
        rnd_nxt   = rnd_q;
        state_nxt = state_q;
        hold_nxt  = hold_q;
        in_ready  = 1'b0;
        key_req   = 1'b0;
        key_round = 4'd0;
        dp_last   = 1'b0;
        out_valid = 1'b0;
        out_block = 128'd0;
        busy      = 1'b1;

        case (st_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    hold_nxt = in_block;
                    rnd_nxt  = 4'd0;
                    st_nxt   = ROUND;
                end
            end
            ROUND: begin
                key_req   = 1'b1;
                key_round = rnd_q;
                dp_last   = (rnd_q == LAST_RND);
                if (key_ack) begin
                    // Round 0 is the bare initial add_round_key; the datapath handles the rest.
                    state_nxt = (rnd_q == 4'd0) ? (hold_q ^ key_in) : dp_result;
                    if (rnd_q == LAST_RND) begin
                        st_nxt = DONE;
                    end else begin
                        rnd_nxt = rnd_q + 4'd1;
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_block = state_q;
                if (out_ready) begin
                    st_nxt  = IDLE;
                    rnd_nxt = 4'd0;
                end
            end
            default: begin
                st_nxt = IDLE;
            end
        endcase
    end

    assign dp_state = state_q;
    assign dp_key   = key_in;

endmodule

// File: tb/tb_aes_round_controller.sv
// Bench for aes_round_controller: behavioural round datapath and key schedule, scoreboard-checked ciphertexts.
module tb_aes_round_controller;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_block = 128'd0;
    logic         key_req;
    logic [3:0]   key_round;
    logic         key_ack = 1'b1;
    logic [127:0] key_in;
    logic [127:0] dp_state;
    logic [127:0] dp_key;
    logic         dp_last;
    logic [127:0] dp_result;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_block;
    logic         busy;

    aes_round_controller #(.NUM_ROUNDS(10)) dut (
        .clk(clk), .n_rst(n_rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
        .key_req(key_req), .key_round(key_round), .key_ack(key_ack), .key_in(key_in),
        .dp_state(dp_state), .dp_key(dp_key), .dp_last(dp_last), .dp_result(dp_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] sub_byte(input logic [7:0] x);
        return SBOX[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   c0, c1, c2, c3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = sub_byte(s[127 - 8*i -: 8]);
        for (int row = 0; row < 4; row++)
            for (int col = 0; col < 4; col++)
                b[row + 4*col] = a[row + 4*((col + row) % 4)];
        if (!last) begin
            for (int col = 0; col < 4; col++) begin
                c0 = b[4*col]; c1 = b[4*col+1]; c2 = b[4*col+2]; c3 = b[4*col+3];
                b[4*col]   = xtime(c0) ^ xtime(c1) ^ c1 ^ c2 ^ c3;
                b[4*col+1] = c0 ^ xtime(c1) ^ xtime(c2) ^ c2 ^ c3;
                b[4*col+2] = c0 ^ c1 ^ xtime(c2) ^ xtime(c3) ^ c3;
                b[4*col+3] = xtime(c0) ^ c0 ^ c1 ^ c2 ^ xtime(c3);
            end
        end
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = b[i];
        return r ^ k;
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] key, input logic [3:0] n);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        int          idx;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sub_byte(t[23:16]), sub_byte(t[15:8]), sub_byte(t[7:0]), sub_byte(t[31:24])}
                    ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        idx = (n > 4'd10) ? 10 : int'(n);
        return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
    endfunction

    logic [127:0] in_key = 128'd0;
    logic [127:0] inflight_key = 128'd0;

    assign key_in    = round_key(inflight_key, key_round);
    assign dp_result = aes_round(dp_state, dp_key, dp_last);

    always @(posedge clk) if (in_valid && in_ready) inflight_key <= in_key;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [127:0] ct;
        int           lat;
    } exp_t;
    exp_t sb [$];

    // Key schedule responder: optional 3-cycle stalls on rounds 0, 5 and 10.
    logic       stall_en = 1'b0;
    int         stall_cnt = 0;
    logic       prev_stall = 1'b0;
    logic [3:0] prev_round = 4'd0;

    always @(posedge clk) begin
        #1;
        if (n_rst && prev_stall) chk("key_round_held", 128'(key_round), 128'(prev_round));
        prev_stall = 1'b0;
        if (!n_rst) begin
            stall_cnt = 0;
            key_ack   = 1'b1;
        end else if (key_req && stall_en && stall_cnt < 3 &&
                     (key_round == 4'd0 || key_round == 4'd5 || key_round == 4'd10)) begin
            key_ack    = 1'b0;
            stall_cnt++;
            prev_stall = 1'b1;
            prev_round = key_round;
        end else begin
            key_ack = 1'b1;
            if (key_req) stall_cnt = 0;
        end
    end

    logic         ov_prev = 1'b0;
    logic [127:0] held_blk = 128'd0;
    int           acc_cyc = 0;
    int           hand_cyc = 0;
    logic         hand_seen = 1'b0;
    logic         b2b_chk = 1'b0;
    logic [3:0]   exp_round = 4'd0;
    exp_t         e;

    always @(negedge clk) begin
        if (!n_rst) begin
            ov_prev   = 1'b0;
            exp_round = 4'd0;
            hand_seen = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                if (b2b_chk && hand_seen) chk("b2b_accept_cycle", 128'(cyc), 128'(hand_cyc + 1));
                hand_seen = 1'b0;
                acc_cyc   = cyc;
            end
            if (key_req) begin
                chk("dp_last", 128'(dp_last), 128'(key_round == 4'd10));
                if (key_ack) begin
                    chk("key_round_order", 128'(key_round), 128'(exp_round));
                    exp_round = (exp_round == 4'd10) ? 4'd0 : exp_round + 4'd1;
                end
            end
            if (out_valid) begin
                if (!ov_prev) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_out_valid", 128'(out_valid), 128'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("ciphertext", out_block, e.ct);
                        chk("latency", 128'(cyc - acc_cyc), 128'(e.lat));
                    end
                    held_blk = out_block;
                end else begin
                    chk("out_block_stable", out_block, held_blk);
                end
                if (out_ready) begin
                    hand_seen = 1'b1;
                    hand_cyc  = cyc;
                end
            end
            ov_prev = out_valid && !out_ready;
        end
    end

    task automatic check_reset_outputs();
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_key_req", 128'(key_req), 128'd0);
        chk("rst_key_round", 128'(key_round), 128'd0);
        chk("rst_dp_last", 128'(dp_last), 128'd0);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_block", out_block, 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_dp_state", dp_state, 128'd0);
    endtask

    task automatic wait_in_ready(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) chk({name, "_accept_timeout"}, 128'(in_ready), 128'd1);
    endtask

    task automatic start_block(input logic [127:0] pt, input logic [127:0] k,
                               input logic [127:0] ct, input int lat);
        @(posedge clk); #1;
        in_block = pt;
        in_key   = k;
        in_valid = 1'b1;
        sb.push_back('{ct: ct, lat: lat});
        wait_in_ready("start");
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 200);
        if (!out_valid) chk({name, "_out_timeout"}, 128'(out_valid), 128'd1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 200);
        if (busy) chk({name, "_idle_timeout"}, 128'(busy), 128'd0);
    endtask

    initial begin
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;

        // Plain FIPS-197 C.1 vector, consumer always ready.
        out_ready = 1'b1;
        start_block(PT1, K1, CT1, 12);
        wait_out("t1");
        wait_idle("t1");

        // Key stalls of 3 cycles on rounds 0, 5 and 10.
        stall_en = 1'b1;
        start_block(PT1, K1, CT1, 21);
        wait_out("t2");
        wait_idle("t2");
        stall_en = 1'b0;

        // Output backpressure with stray in_valid pulses.
        out_ready = 1'b0;
        start_block(PT2, K2, CT2, 12);
        wait_out("t3");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid = (i == 1 || i == 3);
            in_block = PT1;
            in_key   = K1;
            @(negedge clk);
            chk("t3_in_ready_low", 128'(in_ready), 128'd0);
            chk("t3_out_valid_high", 128'(out_valid), 128'd1);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        wait_idle("t3");
        repeat (3) begin
            @(negedge clk);
            chk("t3_stays_idle", 128'(busy), 128'd0);
        end

        // Reset in the middle of round 4; the partial block is dropped.
        out_ready = 1'b1;
        start_block(PT1, K1, CT1, 12);
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(key_req && key_round == 4'd4) && n < 100);
            chk("t4_reached_round4", 128'(key_round), 128'd4);
        end
        n_rst = 1'b0;
        #1;
        check_reset_outputs();
        sb.delete();
        @(posedge clk); #1;
        n_rst = 1'b1;
        start_block(PT2, K2, CT2, 12);
        wait_out("t4");
        wait_idle("t4");

        // Back-to-back blocks with in_valid held high.
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_block = PT1;
        in_key   = K1;
        in_valid = 1'b1;
        sb.push_back('{ct: CT1, lat: 12});
        wait_in_ready("t5a");
        @(posedge clk); #1;
        b2b_chk  = 1'b1;
        in_block = PT2;
        in_key   = K2;
        sb.push_back('{ct: CT2, lat: 12});
        wait_in_ready("t5b");
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out("t5");
        wait_idle("t5");
        b2b_chk = 1'b0;

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 128'(sb.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
